// File: rtl/pam4_pkg.sv
// Shared PAM4 definitions: Gray code points, level-to-fixed-point helper, PRBS9 taps.
// Used by the TX mapper and by the RX slicer / BER checker so both ends agree on coding.
// Pure constants and functions; no state.
package pam4_pkg;

  // Gray-coded bit pair for each PAM4 level (adjacent levels differ in one bit)
  localparam logic [1:0] GRAY_M3 = 2'b00;
  localparam logic [1:0] GRAY_M1 = 2'b01;
  localparam logic [1:0] GRAY_P1 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  // PRBS9 polynomial x^9 + x^5 + 1: feedback is s[8] ^ s[4]
  localparam int PRBS9_LEN    = 9;
  localparam int PRBS9_TAP_HI = 8;
  localparam int PRBS9_TAP_LO = 4;

  // Integer PAM4 level (-3, -1, +1, +3) for a Gray-coded bit pair
  function automatic int gray_to_level(input logic [1:0] g);
    case (g)
      GRAY_M3: return -3;
      GRAY_M1: return -1;
      GRAY_P1: return 1;
      default: return 3;
    endcase
  endfunction

  // Level scaled to Q(.,nbf) fixed point; the caller narrows it to its sample width
  function automatic int level_fx(input logic [1:0] g, input int nbf);
    return gray_to_level(g) * (1 << nbf);
  endfunction

endpackage

// File: rtl/prbs9_gen.sv
// PRBS9 generator (x^9+x^5+1) producing two bits per step, first bit in the MSB.
// Latency: o_bits shows the pair the next step will consume; state updates on the step edge.
// No backpressure: state holds whenever i_step is low.
module prbs9_gen
  import pam4_pkg::*;
#(
  parameter logic [8:0] SEED = 9'h1FF
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_step,
  output logic [1:0] o_bits
);

  // An all-zero seed would lock the LFSR, so it is replaced by all ones
  localparam logic [PRBS9_LEN-1:0] SEED_EFF = (SEED == 9'h000) ? 9'h1FF : SEED;

  logic [PRBS9_LEN-1:0] state;
  logic [PRBS9_LEN-1:0] mid;
  logic [PRBS9_LEN-1:0] state_nxt;

  // Two single-bit LFSR steps chained in one cycle; each step outputs s[8] before shifting
  always_comb begin
    mid       = {state[PRBS9_LEN-2:0], state[PRBS9_TAP_HI] ^ state[PRBS9_TAP_LO]};
    state_nxt = {mid[PRBS9_LEN-2:0], mid[PRBS9_TAP_HI] ^ mid[PRBS9_TAP_LO]};
    o_bits    = {state[PRBS9_TAP_HI], mid[PRBS9_TAP_HI]};
  end

  // LFSR register: reseeds on reset, advances two bits per step
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= SEED_EFF;
    end else if (i_step) begin
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/pam4_tx_mapper.sv
// PAM4 TX symbol source: PRBS9 or external bit pairs, Gray-mapped to fixed-point levels, zero-stuffed to OS.
// Latency: 1 cycle from an advancing slot to o_sample/o_gray/o_sym_strobe/o_valid.
// No backpressure: external bits are taken whenever o_ready is high; without enable&valid all state holds.
module pam4_tx_mapper
  import pam4_pkg::*;
#(
  parameter int         NB   = 18,
  parameter int         NBF  = 15,
  parameter int         OS   = 4,
  parameter logic [8:0] SEED = 9'h1FF
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_valid,
  input  logic          i_prbs_mode,
  input  logic [1:0]    i_bits,
  output logic          o_ready,
  output logic [NB-1:0] o_sample,
  output logic          o_valid,
  output logic          o_sym_strobe,
  output logic [1:0]    o_gray
);

  // +3 must be representable, which needs at least 3 integer bits including sign
  if (NB - NBF < 3) begin : g_bad_width
    $error("pam4_tx_mapper: NB-NBF must be at least 3");
  end
  if (OS < 1) begin : g_bad_os
    $error("pam4_tx_mapper: OS must be at least 1");
  end

  localparam int            PW         = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(OS - 1);

  localparam logic [NB-1:0] LVL_M3 = NB'(level_fx(GRAY_M3, NBF));
  localparam logic [NB-1:0] LVL_M1 = NB'(level_fx(GRAY_M1, NBF));
  localparam logic [NB-1:0] LVL_P1 = NB'(level_fx(GRAY_P1, NBF));
  localparam logic [NB-1:0] LVL_P3 = NB'(level_fx(GRAY_P3, NBF));

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nxt;
  logic          adv;
  logic          fetch;
  logic [1:0]    prbs_bits;
  logic [1:0]    pair;
  logic [NB-1:0] level;

  // The LFSR only moves when a PRBS symbol is actually fetched, so external mode leaves it intact
  prbs9_gen #(.SEED(SEED)) u_prbs (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_step  (fetch & i_prbs_mode),
    .o_bits  (prbs_bits)
  );

  // Slot qualification, phase wrap, source mux and Gray-to-level map
  always_comb begin
    adv       = i_enable & i_valid;
    fetch     = adv & (phase == '0);
    phase_nxt = (phase == PHASE_LAST) ? '0 : phase + PW'(1);
    pair      = i_prbs_mode ? prbs_bits : i_bits;
    case (pair)
      GRAY_M3: level = LVL_M3;
      GRAY_M1: level = LVL_M1;
      GRAY_P1: level = LVL_P1;
      default: level = LVL_P3;
    endcase
  end

  // External data is consumed exactly on a fetch slot; held low during reset
  assign o_ready = ~i_reset & ~i_prbs_mode & fetch;

  // Phase counter and output registers; stuffed phases emit zero while o_gray keeps the symbol
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      phase        <= '0;
      o_sample     <= '0;
      o_valid      <= 1'b0;
      o_sym_strobe <= 1'b0;
      o_gray       <= 2'b00;
    end else begin
      o_valid      <= adv;
      o_sym_strobe <= fetch;
      if (adv) begin
        phase <= phase_nxt;
        if (fetch) begin
          o_sample <= level;
          o_gray   <= pair;
        end else begin
          o_sample <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pam4_tx_mapper.sv
// Self-checking bench for pam4_tx_mapper: OS=1 and OS=4 instances driven by the same inputs.
// Reference: PRBS9 bit sequence from the recurrence b[k] = b[k-9] ^ b[k-5], symbols by slot count.
// Outputs are sampled 1 time unit after the rising edge.
module tb_pam4_tx_mapper;

  localparam int NB  = 18;
  localparam int NBF = 15;
  localparam int OSV [2] = '{1, 4};

  logic clk = 1'b0;
  logic rst, en, vld, mode;
  logic [1:0] bits;

  logic rdy1, val1, str1;
  logic rdy4, val4, str4;
  logic signed [NB-1:0] s1, s4;
  logic [1:0] g1, g4;

  always #5 clk = ~clk;

  pam4_tx_mapper #(.NB(NB), .NBF(NBF), .OS(1), .SEED(9'h1FF)) dut1 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_prbs_mode(mode),
    .i_bits(bits), .o_ready(rdy1), .o_sample(s1), .o_valid(val1), .o_sym_strobe(str1), .o_gray(g1)
  );

  pam4_tx_mapper #(.NB(NB), .NBF(NBF), .OS(4), .SEED(9'h1FF)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_valid(vld), .i_prbs_mode(mode),
    .i_bits(bits), .o_ready(rdy4), .o_sample(s4), .o_valid(val4), .o_sym_strobe(str4), .o_gray(g4)
  );

  int checks = 0;
  int failures = 0;

  // Reference PRBS9 output bit sequence
  bit pb [0:8191];

  // Behavioural model per instance (0: OS=1, 1: OS=4)
  int         cnt [2];
  int         kb [2];
  logic [1:0] mg [2];
  int         m_sample [2];
  bit         m_valid [2];
  bit         m_strobe [2];

  int exp6 [6] = '{32768, 32768, 32768, 32768, 98304, -98304};
  logic [1:0] expg6 [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b00};

  int ref_q [$];

  function automatic int level_of(input logic [1:0] g);
    case (g)
      2'b00: return -3 * (1 << NBF);
      2'b01: return -1 * (1 << NBF);
      2'b11: return 1 * (1 << NBF);
      default: return 3 * (1 << NBF);
    endcase
  endfunction

  // Receive slicer: thresholds midway between levels, Gray output
  function automatic logic [1:0] slicer(input int s);
    if (s < -2 * (1 << NBF)) return 2'b00;
    if (s < 0) return 2'b01;
    if (s < 2 * (1 << NBF)) return 2'b11;
    return 2'b10;
  endfunction

  // One clock: advance the model with the inputs currently applied, then sample after the edge
  task automatic tick();
    bit a;
    a = en && vld;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        cnt[d] = 0; kb[d] = 0; mg[d] = 2'b00;
        m_sample[d] = 0; m_valid[d] = 0; m_strobe[d] = 0;
      end else if (a) begin
        if (cnt[d] % OSV[d] == 0) begin
          if (mode) begin
            mg[d] = {pb[kb[d]], pb[kb[d] + 1]};
            kb[d] += 2;
          end else begin
            mg[d] = bits;
          end
          m_sample[d] = level_of(mg[d]);
          m_strobe[d] = 1;
        end else begin
          m_sample[d] = 0;
          m_strobe[d] = 0;
        end
        m_valid[d] = 1;
        cnt[d]++;
      end else begin
        m_valid[d] = 0;
        m_strobe[d] = 0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; en = 0; vld = 0; mode = 1; bits = 2'b00;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; vld = 1; mode = 0; bits = 2'b10;
    tick();
    #1;
    checks++;
    if (rdy1 !== 1'b0 || rdy4 !== 1'b0) begin
      failures++; $display("FAIL reset_ready: got rdy1=%b rdy4=%b want 0 0", rdy1, rdy4);
    end
    checks++;
    if (s1 !== 0 || s4 !== 0) begin
      failures++; $display("FAIL reset_sample: got %0d %0d want 0 0", s1, s4);
    end
    checks++;
    if ({val1, str1, val4, str4} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags: got %b want 0000", {val1, str1, val4, str4});
    end
    checks++;
    if (g1 !== 2'b00 || g4 !== 2'b00) begin
      failures++; $display("FAIL reset_gray: got %b %b want 00 00", g1, g4);
    end
    rst = 0;
  endtask

  task automatic test_prbs_os1();
    do_reset();
    en = 1; vld = 1; mode = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (val1 !== 1'b1 || str1 !== 1'b1) begin
        failures++; $display("FAIL os1_flags[%0d]: got v=%b s=%b want 1 1", i, val1, str1);
      end
      checks++;
      if (s1 !== exp6[i]) begin
        failures++; $display("FAIL os1_sample[%0d]: got %0d want %0d", i, s1, exp6[i]);
      end
      checks++;
      if (g1 !== expg6[i]) begin
        failures++; $display("FAIL os1_gray[%0d]: got %b want %b", i, g1, expg6[i]);
      end
    end
  endtask

  task automatic test_prbs_os4();
    logic [1:0] held;
    do_reset();
    en = 1; vld = 1; mode = 1;
    held = 2'b00;
    ref_q.delete();
    for (int i = 0; i < 40; i++) begin
      tick();
      ref_q.push_back(m_sample[1]);
      checks++;
      if (val4 !== 1'b1 || str4 !== (i % 4 == 0)) begin
        failures++; $display("FAIL os4_flags[%0d]: got v=%b s=%b want 1 %0d", i, val4, str4, i % 4 == 0);
      end
      checks++;
      if (s4 !== m_sample[1]) begin
        failures++; $display("FAIL os4_sample[%0d]: got %0d want %0d", i, s4, m_sample[1]);
      end
      if (i % 4 == 0) held = mg[1];
      checks++;
      if (g4 !== held) begin
        failures++; $display("FAIL os4_gray_hold[%0d]: got %b want %b", i, g4, held);
      end
    end
  endtask

  task automatic test_external();
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int sym;
    bit was_rdy;
    do_reset();
    en = 1; vld = 1; mode = 0;
    sym = 0;
    for (int i = 0; i < 16; i++) begin
      bits = seq[sym % 4];
      #1;
      checks++;
      if (rdy4 !== (i % 4 == 0) || rdy1 !== 1'b1) begin
        failures++; $display("FAIL ext_ready[%0d]: got rdy4=%b rdy1=%b want %0d 1", i, rdy4, rdy1, i % 4 == 0);
      end
      was_rdy = (i % 4 == 0);
      tick();
      checks++;
      if (s1 !== level_of(bits) || g1 !== bits) begin
        failures++; $display("FAIL ext_os1[%0d]: got %0d/%b want %0d/%b", i, s1, g1, level_of(bits), bits);
      end
      if (was_rdy) begin
        checks++;
        if (s4 !== level_of(seq[sym % 4]) || str4 !== 1'b1) begin
          failures++; $display("FAIL ext_sample[%0d]: got %0d s=%b want %0d 1", i, s4, str4, level_of(seq[sym % 4]));
        end
        sym++;
      end
    end
    // LFSR untouched by external symbols: PRBS resumes from its very first pair
    mode = 1;
    tick();
    checks++;
    if (s4 !== 32768 || g4 !== 2'b11 || s1 !== 32768) begin
      failures++; $display("FAIL ext_lfsr_hold: got %0d/%b dut1 %0d want 32768/11", s4, g4, s1);
    end
  endtask

  task automatic test_valid_toggle();
    int idx;
    bit a;
    do_reset();
    mode = 1;
    idx = 0;
    for (int c = 0; c < 400 && idx < 40; c++) begin
      en = ($urandom_range(0, 3) != 0);
      vld = $urandom_range(0, 1);
      a = en && vld;
      tick();
      if (!a) begin
        checks++;
        if (val4 !== 1'b0 || str4 !== 1'b0 || val1 !== 1'b0) begin
          failures++; $display("FAIL toggle_frozen[%0d]: got v4=%b s4=%b v1=%b want 0", c, val4, str4, val1);
        end
      end else begin
        checks++;
        if (val4 !== 1'b1 || s4 !== ref_q[idx] || str4 !== (idx % 4 == 0)) begin
          failures++; $display("FAIL toggle_stream[%0d]: got v=%b %0d s=%b want 1 %0d %0d", idx, val4, s4, str4, ref_q[idx], idx % 4 == 0);
        end
        idx++;
      end
    end
    checks++;
    if (idx < 40) begin
      failures++; $display("FAIL toggle_timeout: got %0d samples want 40", idx);
    end
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e < 2; e++) begin
      do_reset();
      en = 1; vld = 1; mode = 1;
      for (int i = 0; i < 26; i++) tick();
      rst = 1; en = e[0]; vld = 1;
      tick();
      checks++;
      if (s1 !== 0 || s4 !== 0 || {val1, str1, val4, str4} !== 4'b0000 || g1 !== 2'b00 || g4 !== 2'b00) begin
        failures++; $display("FAIL midreset_outputs[en=%0d]: got %0d %0d %b %b %b want all 0", e, s1, s4, {val1, str1, val4, str4}, g1, g4);
      end
      rst = 0; en = 1; vld = 1;
      for (int i = 0; i < 24; i++) begin
        tick();
        if (i < 6) begin
          checks++;
          if (s1 !== exp6[i]) begin
            failures++; $display("FAIL midreset_os1[%0d]: got %0d want %0d", i, s1, exp6[i]);
          end
        end
        if (i % 4 == 0) begin
          checks++;
          if (s4 !== exp6[i / 4] || str4 !== 1'b1) begin
            failures++; $display("FAIL midreset_os4[%0d]: got %0d s=%b want %0d 1", i, s4, str4, exp6[i / 4]);
          end
        end
      end
    end
  endtask

  task automatic test_long_run();
    bit rx [0:2043];
    int model_err, slicer_err, period_err;
    do_reset();
    en = 1; vld = 1; mode = 1;
    model_err = 0; slicer_err = 0; period_err = 0;
    for (int i = 0; i < 1022; i++) begin
      tick();
      rx[2 * i] = g1[1];
      rx[2 * i + 1] = g1[0];
      if (g1 !== {pb[2 * i], pb[2 * i + 1]} || val1 !== 1'b1) model_err++;
      if (g1 !== slicer(int'(s1))) slicer_err++;
    end
    for (int j = 511; j < 2044; j++) begin
      if (rx[j] !== rx[j - 511]) period_err++;
    end
    checks++;
    if (model_err != 0) begin
      failures++; $display("FAIL long_model: got %0d symbol errors want 0", model_err);
    end
    checks++;
    if (slicer_err != 0) begin
      failures++; $display("FAIL long_slicer: got %0d gray errors want 0", slicer_err);
    end
    checks++;
    if (period_err != 0) begin
      failures++; $display("FAIL long_period: got %0d bit errors want 0", period_err);
    end
  endtask

  initial begin
    for (int k = 0; k < 9; k++) pb[k] = 1'b1;
    for (int k = 9; k < 8192; k++) pb[k] = pb[k - 9] ^ pb[k - 5];
    rst = 1; en = 0; vld = 0; mode = 1; bits = 2'b00;
    test_reset();
    test_prbs_os1();
    test_prbs_os4();
    test_external();
    test_valid_toggle();
    test_reset_mid();
    test_long_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
